imm_enc: RTL and testbench

Streaming RISC-V instruction encoder, the inverse of the immediate expander. It takes an immediate class selector, a 32-bit immediate and register/function fields, and packs them into a 32-bit instruction word. It validates that the immediate is representable in the selected format and flags it when it is not. It sits in the instruction-injection/self-test path, feeding encoded words to the instruction memory writer through a valid/ready handshake.

---
 rtl/imm_enc_pkg.sv | 32 +++
 rtl/imm_enc_pack.sv | 67 ++++++
 rtl/imm_enc.sv | 122 ++++++++++++
 tb/tb_imm_enc.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_enc_pkg.sv
// Shared definitions for the RISC-V instruction encoder: immediate class
// selectors, error codes and the request bundle carried through stage 1.
package imm_enc_pkg;

  // Immediate class selectors (same encoding as the immediate expander).
  localparam logic [2:0] IMM_R_SHAMT = 3'b000;
  localparam logic [2:0] IMM_I       = 3'b001;
  localparam logic [2:0] IMM_S       = 3'b010;
  localparam logic [2:0] IMM_B       = 3'b011;
  localparam logic [2:0] IMM_U       = 3'b100;

  // Error codes reported alongside each encoded word.
  typedef enum logic [1:0] {
    ENC_OK    = 2'd0,
    ENC_RANGE = 2'd1,
    ENC_ALIGN = 2'd2,
    ENC_SEL   = 2'd3
  } enc_err_e;

  // One encode request as captured by stage 1.
  typedef struct packed {
    logic [2:0]  sel;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
  } enc_req_t;

endpackage

// File: rtl/imm_enc_pack.sv
// Combinational packer: places the immediate and register/function fields
// into the 32-bit instruction layout chosen by sel, and classifies whether
// the immediate fits that layout. Out-of-range or misaligned immediates are
// still packed (upper bits simply dropped) so the word can be delivered.
module imm_pack
  import imm_enc_pkg::*;
(
  input  enc_req_t    req_i,
  output logic [31:0] inst_o,
  output logic [1:0]  err_o
);

  enc_err_e    err_e;
  logic [31:0] imm;
  logic        fits_s12;
  logic        fits_s13;
  logic        fits_u5;

  assign imm = req_i.imm;

  // Signed 12-bit fit: everything from bit 11 upward is a copy of the sign.
  assign fits_s12 = (imm[31:11] == {21{imm[11]}});
  // Signed 13-bit fit for branch offsets.
  assign fits_s13 = (imm[31:12] == {20{imm[12]}});
  // Shift amounts are unsigned 5-bit.
  assign fits_u5  = (imm[31:5] == 27'd0);

  // Field placement and error classification; illegal sel wins over
  // alignment, which wins over range.
  always_comb begin
    inst_o = 32'd0;
    err_e  = ENC_OK;
    case (req_i.sel)
      IMM_R_SHAMT: begin
        inst_o = {req_i.funct7, imm[4:0], req_i.rs1, req_i.funct3,
                  req_i.rd, req_i.opcode};
        if (!fits_u5) err_e = ENC_RANGE;
      end
      IMM_I: begin
        inst_o = {imm[11:0], req_i.rs1, req_i.funct3, req_i.rd, req_i.opcode};
        if (!fits_s12) err_e = ENC_RANGE;
      end
      IMM_S: begin
        inst_o = {imm[11:5], req_i.rs2, req_i.rs1, req_i.funct3,
                  imm[4:0], req_i.opcode};
        if (!fits_s12) err_e = ENC_RANGE;
      end
      IMM_B: begin
        inst_o = {imm[12], imm[10:5], req_i.rs2, req_i.rs1, req_i.funct3,
                  imm[4:1], imm[11], req_i.opcode};
        if (imm[0])         err_e = ENC_ALIGN;
        else if (!fits_s13) err_e = ENC_RANGE;
      end
      IMM_U: begin
        inst_o = {imm[31:12], req_i.rd, req_i.opcode};
        if (imm[11:0] != 12'd0) err_e = ENC_ALIGN;
      end
      default: begin
        inst_o = 32'd0;
        err_e  = ENC_SEL;
      end
    endcase
  end

  assign err_o = err_e;

endmodule

// File: rtl/imm_enc.sv
// Streaming instruction encoder: two-stage valid/ready pipeline around the
// combinational packer, plus saturating counts of delivered good/bad words.
// Stage 1 holds the raw request, stage 2 holds the packed word and drives
// the outputs.
module imm_enc
  import imm_enc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       sel,
  input  logic [31:0]      imm,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      inst,
  output logic [1:0]       err,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  enc_req_t          req_in;
  enc_req_t          req_p1_q;
  logic              vld_p1_q, vld_p1_d;
  logic              vld_p2_q, vld_p2_d;
  logic [31:0]       inst_p2_q;
  logic [1:0]        err_p2_q;
  logic [31:0]       inst_pk;
  logic [1:0]        err_pk;
  logic [CNT_W-1:0]  ok_cnt_q, ok_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic              accept;
  logic              load_p2;
  logic              xfer;

  assign req_in = '{sel: sel, imm: imm, opcode: opcode, rd: rd, rs1: rs1,
                    rs2: rs2, funct3: funct3, funct7: funct7};

  // Handshake: stage 2 drains on out_ready, stage 1 advances when stage 2
  // is free or draining, and a new request fits whenever either stage has
  // room or the pipe is moving. in_ready is held high while in reset.
  assign xfer     = vld_p2_q && out_ready;
  assign load_p2  = vld_p1_q && (!vld_p2_q || out_ready);
  assign in_ready = rst || !vld_p1_q || !vld_p2_q || out_ready;
  assign accept   = in_valid && in_ready && !rst;

  // Next-state for stage valids and counters.
  always_comb begin
    vld_p1_d  = vld_p1_q;
    vld_p2_d  = vld_p2_q;
    ok_cnt_d  = ok_cnt_q;
    err_cnt_d = err_cnt_q;
    if (accept)       vld_p1_d = 1'b1;
    else if (load_p2) vld_p1_d = 1'b0;
    if (load_p2)      vld_p2_d = 1'b1;
    else if (xfer)    vld_p2_d = 1'b0;
    if (xfer) begin
      if (err_p2_q == ENC_OK) ok_cnt_d  = sat_inc(ok_cnt_q);
      else                    err_cnt_d = sat_inc(err_cnt_q);
    end
  end

  // Control state: stage valids and statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      ok_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      ok_cnt_q  <= ok_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // ---- stage 1: capture the raw request ----
  // Request data is only written on accept; its valid bit guards it.
  always_ff @(posedge clk) begin
    if (accept) req_p1_q <= req_in;
  end

  imm_pack u_pack (
    .req_i  (req_p1_q),
    .inst_o (inst_pk),
    .err_o  (err_pk)
  );

  // ---- stage 2: packed word and error code, driving the outputs ----
  // Cleared on reset so the output bus reads zero; otherwise held while
  // the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_p2_q <= 32'd0;
      err_p2_q  <= ENC_OK;
    end else if (load_p2) begin
      inst_p2_q <= inst_pk;
      err_p2_q  <= err_pk;
    end
  end

  assign out_valid = vld_p2_q;
  assign inst      = inst_p2_q;
  assign err       = err_p2_q;
  assign ok_cnt    = ok_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_imm_enc.sv
// Bench for imm_enc: directed encodings, backpressure, streaming, random
// handshaking, mid-flight reset and counter saturation (second instance
// with 2-bit counters shares the stimulus).
module tb_imm_enc;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready;
  logic [2:0]  sel, funct3;
  logic [31:0] imm;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;

  logic        in_ready, out_valid;
  logic [31:0] inst;
  logic [1:0]  err;
  logic [15:0] ok_cnt, err_cnt;

  logic        in_ready2, out_valid2;
  logic [31:0] inst2;
  logic [1:0]  err2;
  logic [1:0]  ok_cnt2, err_cnt2;

  imm_enc #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .imm(imm), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .out_valid(out_valid),
    .out_ready(out_ready), .inst(inst), .err(err),
    .ok_cnt(ok_cnt), .err_cnt(err_cnt)
  );

  imm_enc #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .sel(sel), .imm(imm), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .out_valid(out_valid2),
    .out_ready(out_ready), .inst(inst2), .err(err2),
    .ok_cnt(ok_cnt2), .err_cnt(err_cnt2)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_ok_del = 0;
  int n_err_del = 0;
  logic [33:0] exp_q[$];

  logic [31:0] bnd [0:9] = '{32'd31, 32'd32, 32'd2047, 32'd2048,
                             32'hFFFFF800, 32'hFFFFF7FF, 32'd4094,
                             32'd4096, 32'hFFFFF000, 32'hFFFFEFFE};

  // Reference: numeric range tests on the signed value, then field layout.
  function automatic logic [33:0] model(input logic [2:0] s, input logic [31:0] i,
                                        input logic [6:0] op, input logic [4:0] d,
                                        input logic [4:0] r1, input logic [4:0] r2,
                                        input logic [2:0] f3, input logic [6:0] f7);
    logic [31:0] w;
    logic [1:0]  e;
    longint      v;
    v = longint'($signed(i));
    w = 32'd0;
    e = 2'd0;
    case (s)
      3'd0: begin
        w = {f7, i[4:0], r1, f3, d, op};
        e = (i > 32'd31) ? 2'd1 : 2'd0;
      end
      3'd1: begin
        w = {i[11:0], r1, f3, d, op};
        e = (v < -2048 || v > 2047) ? 2'd1 : 2'd0;
      end
      3'd2: begin
        w = {i[11:5], r2, r1, f3, i[4:0], op};
        e = (v < -2048 || v > 2047) ? 2'd1 : 2'd0;
      end
      3'd3: begin
        w = {i[12], i[10:5], r2, r1, f3, i[4:1], i[11], op};
        if (i % 2 != 0)                 e = 2'd2;
        else if (v < -4096 || v > 4095) e = 2'd1;
      end
      3'd4: begin
        w = {i[31:12], d, op};
        e = (i % 4096 != 0) ? 2'd2 : 2'd0;
      end
      default: begin
        w = 32'd0;
        e = 2'd3;
      end
    endcase
    return {e, w};
  endfunction

  function automatic int sat(input int n, input int mx);
    return (n > mx) ? mx : n;
  endfunction

  task automatic rand_req(input bit ok_only);
    int m;
    opcode = 7'($urandom);
    rd     = 5'($urandom);
    rs1    = 5'($urandom);
    rs2    = 5'($urandom);
    funct3 = 3'($urandom);
    funct7 = 7'($urandom);
    if (ok_only) begin
      sel = 3'd1;
      imm = 32'($urandom_range(0, 2047));
    end else begin
      sel = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7))
                                        : 3'($urandom_range(0, 4));
      m = $urandom_range(0, 3);
      case (m)
        0: imm = 32'($urandom_range(0, 63)) - 32'd32;
        1: imm = bnd[$urandom_range(0, 9)];
        2: imm = $urandom;
        default: imm = $urandom & 32'hFFFFF000;
      endcase
    end
  endtask

  // One clock: sample handshake just before the edge, update scoreboard,
  // advance to 1ns after the edge.
  task automatic step(output bit acc, output bit xf, output bit ov,
                      output logic [31:0] gi, output logic [1:0] ge,
                      output logic [33:0] ex, output bit ex_ok);
    #1;
    acc = in_valid && in_ready && !rst;
    xf  = out_valid && out_ready;
    ov  = out_valid;
    gi  = inst;
    ge  = err;
    ex  = '0;
    ex_ok = 1'b0;
    if (xf && exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      ex_ok = 1'b1;
      if (ex[33:32] == 2'd0) n_ok_del++;
      else                   n_err_del++;
    end
    if (acc) exp_q.push_back(model(sel, imm, opcode, rd, rs1, rs2, funct3, funct7));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bit acc, xf, ov, ex_ok;
    logic [31:0] gi; logic [1:0] ge; logic [33:0] ex;
    rst = 1'b1; out_ready = 1'b0; in_valid = 1'b1;
    rand_req(1'b0);
    step(acc, xf, ov, gi, ge, ex, ex_ok);
    step(acc, xf, ov, gi, ge, ex, ex_ok);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if ({inst, err} !== 34'd0) begin n_fail++; $display("FAIL reset_inst_err got=%h/%0d exp=0/0", inst, err); end
    n_checks++; if ({ok_cnt, err_cnt} !== 32'd0) begin n_fail++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", ok_cnt, err_cnt); end
    n_checks++; if ({in_ready2, out_valid2, inst2, err2, ok_cnt2, err_cnt2} !== {1'b1, 39'd0}) begin
      n_fail++; $display("FAIL reset_dut2 got=%b/%b/%h/%0d/%0d/%0d exp=1/0/0/0/0/0",
                         in_ready2, out_valid2, inst2, err2, ok_cnt2, err_cnt2);
    end
    rst = 1'b0; in_valid = 1'b0;
    exp_q.delete(); n_ok_del = 0; n_err_del = 0;
  endtask

  typedef struct {
    logic [2:0] s; logic [31:0] i; logic [6:0] op; logic [4:0] d, r1, r2;
    logic [2:0] f3; logic [31:0] x; logic [1:0] e;
  } vec_t;

  task automatic test_directed();
    vec_t dv[8];
    bit acc, xf, ov, ex_ok;
    logic [31:0] gi; logic [1:0] ge; logic [33:0] ex;
    dv[0] = '{3'd1, 32'd5,         7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'h00500093, 2'd0};
    dv[1] = '{3'd3, 32'd8,         7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'h00208463, 2'd0};
    dv[2] = '{3'd2, 32'hFFFFFFFC,  7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 32'hFE20AE23, 2'd0};
    dv[3] = '{3'd4, 32'h12345000,  7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h123452B7, 2'd0};
    dv[4] = '{3'd4, 32'h12345001,  7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h123452B7, 2'd2};
    dv[5] = '{3'd1, 32'd2048,      7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'h80000093, 2'd1};
    dv[6] = '{3'd3, 32'd3,         7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'h00208163, 2'd2};
    dv[7] = '{3'd5, 32'd5,         7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'h00000000, 2'd3};
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      sel = dv[k].s; imm = dv[k].i; opcode = dv[k].op; rd = dv[k].d;
      rs1 = dv[k].r1; rs2 = dv[k].r2; funct3 = dv[k].f3; funct7 = 7'd0;
      in_valid = 1'b1;
      step(acc, xf, ov, gi, ge, ex, ex_ok);
      n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL dir_accept[%0d] got=%b exp=1", k, acc); end
      in_valid = 1'b0;
      step(acc, xf, ov, gi, ge, ex, ex_ok);
      n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL dir_early_valid[%0d] got=%b exp=0", k, ov); end
      step(acc, xf, ov, gi, ge, ex, ex_ok);
      n_checks++; if ({ov, ge, gi} !== {1'b1, dv[k].e, dv[k].x}) begin
        n_fail++; $display("FAIL dir_word[%0d] got=v%b e%0d %h exp=v1 e%0d %h", k, ov, ge, gi, dv[k].e, dv[k].x);
      end
    end
    exp_q.delete();
    n_checks++; if ({ok_cnt, err_cnt} !== {16'd4, 16'd4}) begin
      n_fail++; $display("FAIL dir_counters got=%0d/%0d exp=4/4", ok_cnt, err_cnt);
    end
    n_checks++; if ({ok_cnt2, err_cnt2} !== {2'd3, 2'd3}) begin
      n_fail++; $display("FAIL dir_counters_sat got=%0d/%0d exp=3/3", ok_cnt2, err_cnt2);
    end
    n_ok_del = 4; n_err_del = 4;
  endtask

  task automatic test_backpressure();
    bit acc, xf, ov, ex_ok;
    logic [31:0] gi; logic [1:0] ge; logic [33:0] ex;
    logic [33:0] head;
    int nacc = 0;
    int ndel = 0;
    out_ready = 1'b0;
    rand_req(1'b0); in_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step(acc, xf, ov, gi, ge, ex, ex_ok);
      n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL bp_accept[%0d] got=%b exp=1", c, acc); end
      if (acc) begin nacc++; rand_req(1'b0); end
    end
    head = (exp_q.size() > 0) ? exp_q[0] : 34'd0;
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", c, in_ready); end
      n_checks++; if ({out_valid, err, inst} !== {1'b1, head}) begin
        n_fail++; $display("FAIL bp_hold[%0d] got=v%b %h exp=v1 %h", c, out_valid, {err, inst}, head);
      end
      step(acc, xf, ov, gi, ge, ex, ex_ok);
      if (acc) nacc++;
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    for (int c = 0; c < 10 && (nacc < 3 || exp_q.size() > 0); c++) begin
      step(acc, xf, ov, gi, ge, ex, ex_ok);
      if (acc) begin nacc++; in_valid = 1'b0; end
      if (xf) begin
        ndel++;
        n_checks++; if (!ex_ok || {ge, gi} !== ex) begin
          n_fail++; $display("FAIL bp_word got=%h exp=%h", {ge, gi}, ex);
        end
      end
    end
    in_valid = 1'b0;
    n_checks++; if (ndel !== 3 || nacc !== 3) begin
      n_fail++; $display("FAIL bp_count got=acc%0d del%0d exp=acc3 del3", nacc, ndel);
    end
  endtask

  task automatic test_stream();
    bit acc, xf, ov, ex_ok;
    logic [31:0] gi; logic [1:0] ge; logic [33:0] ex;
    out_ready = 1'b1; in_valid = 1'b1; rand_req(1'b0);
    for (int c = 0; c < 30; c++) begin
      step(acc, xf, ov, gi, ge, ex, ex_ok);
      n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL stream_accept[%0d] got=%b exp=1", c, acc); end
      if (c >= 2) begin
        n_checks++; if (ov !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got=%b exp=1", c, ov); end
      end
      if (xf) begin
        n_checks++; if (!ex_ok || {ge, gi} !== ex) begin
          n_fail++; $display("FAIL stream_word[%0d] got=%h exp=%h", c, {ge, gi}, ex);
        end
      end
      rand_req(1'b0);
    end
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step(acc, xf, ov, gi, ge, ex, ex_ok);
      if (xf) begin
        n_checks++; if (!ex_ok || {ge, gi} !== ex) begin
          n_fail++; $display("FAIL stream_drain got=%h exp=%h", {ge, gi}, ex);
        end
      end
    end
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL stream_left got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_random();
    bit acc, xf, ov, ex_ok;
    logic [31:0] gi; logic [1:0] ge; logic [33:0] ex;
    bit stalled = 1'b0;
    logic [33:0] held = '0;
    in_valid = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (!in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        rand_req(1'b0);
      end
      out_ready = ($urandom_range(0, 9) < 6);
      step(acc, xf, ov, gi, ge, ex, ex_ok);
      if (stalled) begin
        n_checks++; if ({ov, ge, gi} !== {1'b1, held}) begin
          n_fail++; $display("FAIL rand_stable[%0d] got=v%b %h exp=v1 %h", c, ov, {ge, gi}, held);
        end
      end
      stalled = ov && !xf;
      held = {ge, gi};
      if (xf) begin
        n_checks++; if (!ex_ok || {ge, gi} !== ex) begin
          n_fail++; $display("FAIL rand_word[%0d] got=%h exp=%h", c, {ge, gi}, ex);
        end
      end
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step(acc, xf, ov, gi, ge, ex, ex_ok);
      if (xf) begin
        n_checks++; if (!ex_ok || {ge, gi} !== ex) begin
          n_fail++; $display("FAIL rand_drain got=%h exp=%h", {ge, gi}, ex);
        end
      end
    end
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL rand_left got=%0d exp=0", exp_q.size()); end
    n_checks++; if ({ok_cnt, err_cnt} !== {16'(sat(n_ok_del, 65535)), 16'(sat(n_err_del, 65535))}) begin
      n_fail++; $display("FAIL rand_counters got=%0d/%0d exp=%0d/%0d", ok_cnt, err_cnt, n_ok_del, n_err_del);
    end
    n_checks++; if ({ok_cnt2, err_cnt2} !== {2'(sat(n_ok_del, 3)), 2'(sat(n_err_del, 3))}) begin
      n_fail++; $display("FAIL rand_counters_sat got=%0d/%0d exp=%0d/%0d", ok_cnt2, err_cnt2,
                         sat(n_ok_del, 3), sat(n_err_del, 3));
    end
  endtask

  task automatic test_reset_midflight();
    bit acc, xf, ov, ex_ok;
    logic [31:0] gi; logic [1:0] ge; logic [33:0] ex;
    int nacc = 0;
    out_ready = 1'b0; in_valid = 1'b1; rand_req(1'b0);
    for (int c = 0; c < 6 && nacc < 2; c++) begin
      step(acc, xf, ov, gi, ge, ex, ex_ok);
      if (acc) begin nacc++; rand_req(1'b0); end
    end
    n_checks++; if (nacc !== 2 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_fill got=acc%0d v%b exp=acc2 v1", nacc, out_valid);
    end
    rst = 1'b1;
    step(acc, xf, ov, gi, ge, ex, ex_ok);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
    n_checks++; if ({out_valid, ok_cnt, err_cnt} !== 33'd0) begin
      n_fail++; $display("FAIL rstmid_clear got=v%b %0d/%0d exp=v0 0/0", out_valid, ok_cnt, err_cnt);
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    exp_q.delete(); n_ok_del = 0; n_err_del = 0;
    for (int c = 0; c < 5; c++) begin
      step(acc, xf, ov, gi, ge, ex, ex_ok);
      n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL rstmid_ghost[%0d] got=%b exp=0", c, ov); end
    end
  endtask

  task automatic test_saturation();
    bit acc, xf, ov, ex_ok;
    logic [31:0] gi; logic [1:0] ge; logic [33:0] ex;
    int nacc = 0;
    out_ready = 1'b1; in_valid = 1'b1; rand_req(1'b1);
    for (int c = 0; c < 12; c++) begin
      step(acc, xf, ov, gi, ge, ex, ex_ok);
      if (acc) begin
        nacc++;
        if (nacc == 5) in_valid = 1'b0;
        else rand_req(1'b1);
      end
      if (xf) begin
        n_checks++; if (!ex_ok || {ge, gi} !== ex) begin
          n_fail++; $display("FAIL sat_word got=%h exp=%h", {ge, gi}, ex);
        end
      end
    end
    n_checks++; if (ok_cnt !== 16'd5) begin n_fail++; $display("FAIL sat_ok_cnt16 got=%0d exp=5", ok_cnt); end
    n_checks++; if ({ok_cnt2, err_cnt2} !== {2'd3, 2'd0}) begin
      n_fail++; $display("FAIL sat_ok_cnt2 got=%0d/%0d exp=3/0", ok_cnt2, err_cnt2);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    sel = 3'd0; imm = 32'd0; opcode = 7'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    funct3 = 3'd0; funct7 = 7'd0;
    test_reset();
    test_directed();
    test_backpressure();
    test_stream();
    test_random();
    test_reset_midflight();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
